// File: rtl/mcu_pkg.sv
// Shared constants and types for the multicycle control unit.
package mcu_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes; modules resize these to their own ALUSEL_W
  localparam int ALUSEL_W_DEF = 5;
  localparam logic [ALUSEL_W_DEF-1:0] ALU_ADD = 5'd0;
  localparam logic [ALUSEL_W_DEF-1:0] ALU_SUB = 5'd1;
  localparam logic [ALUSEL_W_DEF-1:0] ALU_AND = 5'd2;
  localparam logic [ALUSEL_W_DEF-1:0] ALU_OR  = 5'd3;
  localparam logic [ALUSEL_W_DEF-1:0] ALU_SLT = 5'd4;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_IMMEX,
    S_IMMWB,
    S_JUMP
  } state_e;

  // How the ALU operation is chosen in the current state
  typedef enum logic [1:0] {
    ACLS_ADD,
    ACLS_SUB,
    ACLS_RTYPE,
    ACLS_IMM
  } alu_class_e;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction-register fields in, datapath controls out.
interface multicycle_control_unit_if #(
  parameter int ALUSEL_W = 5,
  parameter int CNT_W    = 32
);
  logic [5:0]          OPCODES;
  logic [5:0]          Funct;
  logic                MemReady;
  logic                MemRead;
  logic                MemWrite;
  logic                IorD;
  logic                IRWrite;
  logic                PCWrite;
  logic                Branch;
  logic                RegWrite;
  logic                RegDst;
  logic                MemtoReg;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          PCSrc;
  logic [ALUSEL_W-1:0] ALUSelect;
  logic                Illegal;
  logic                Retired;
  logic [CNT_W-1:0]    InstrCount;

  // Control unit side
  modport slave (
    input  OPCODES, Funct, MemReady,
    output MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUSelect, Illegal,
           Retired, InstrCount
  );

  // Instruction register / datapath side
  modport master (
    output OPCODES, Funct, MemReady,
    input  MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch, RegWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUSelect, Illegal,
           Retired, InstrCount
  );
endinterface

// File: rtl/mcu_alu_decoder.sv
// Combinational ALU operation select from state class, opcode and funct.
module mcu_alu_decoder
  import mcu_pkg::*;
#(
  parameter int ALUSEL_W = 5
) (
  input  alu_class_e          alu_class_i,
  input  logic [5:0]          opcode_i,
  input  logic [5:0]          funct_i,
  output logic [ALUSEL_W-1:0] alu_sel_o,
  output logic                funct_legal_o
);

  logic [ALUSEL_W_DEF-1:0] rtype_sel;
  logic [ALUSEL_W_DEF-1:0] sel;

  // R-type funct decode; unknown functs fall back to ADD and flag illegal
  always_comb begin
    rtype_sel     = ALU_ADD;
    funct_legal_o = 1'b0;
    case (funct_i)
      FN_ADD: begin rtype_sel = ALU_ADD; funct_legal_o = 1'b1; end
      FN_SUB: begin rtype_sel = ALU_SUB; funct_legal_o = 1'b1; end
      FN_AND: begin rtype_sel = ALU_AND; funct_legal_o = 1'b1; end
      FN_OR:  begin rtype_sel = ALU_OR;  funct_legal_o = 1'b1; end
      FN_SLT: begin rtype_sel = ALU_SLT; funct_legal_o = 1'b1; end
      default: ;
    endcase
  end

  // Pick the ALU operation for the class the FSM requested
  always_comb begin
    sel = ALU_ADD;
    case (alu_class_i)
      ACLS_ADD:   sel = ALU_ADD;
      ACLS_SUB:   sel = ALU_SUB;
      ACLS_RTYPE: sel = rtype_sel;
      ACLS_IMM: begin
        case (opcode_i)
          OP_ANDI: sel = ALU_AND;
          OP_ORI:  sel = ALU_OR;
          default: sel = ALU_ADD;
        endcase
      end
    endcase
  end

  assign alu_sel_o = ALUSEL_W'(sel);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM with memory handshake, illegal detection and
// a retired-instruction counter.
//
// state   | meaning
// FETCH   | read instruction, PC+4; wait for MemReady
// DECODE  | compute branch target, dispatch on opcode
// MEMADR  | compute load/store address
// MEMRD   | load access; wait for MemReady
// MEMWB   | write loaded data to register file
// MEMWR   | store access; wait for MemReady
// EXECUTE | R-type ALU operation
// ALUWB   | write R-type result to rd
// BRANCH  | compare for beq, conditional PC update
// IMMEX   | immediate ALU operation
// IMMWB   | write immediate result to rt
// JUMP    | unconditional PC update
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int ALUSEL_W  = 5,
  parameter int IMM_LOGIC = 1,
  parameter int CNT_W     = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  multicycle_control_unit_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  alu_class_e          alu_class;
  logic [ALUSEL_W-1:0] alu_sel;
  logic                funct_legal;
  logic                op_imm;

  logic       mem_read, mem_write, iord, ir_write, pc_write, branch;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       illegal, retire;

  // andi/ori only count as immediate ops when the option is enabled
  assign op_imm = (bus.OPCODES == OP_ADDI) ||
                  ((IMM_LOGIC != 0) &&
                   ((bus.OPCODES == OP_ANDI) || (bus.OPCODES == OP_ORI)));

  mcu_alu_decoder #(.ALUSEL_W(ALUSEL_W)) u_alu_dec (
    .alu_class_i   (alu_class),
    .opcode_i      (bus.OPCODES),
    .funct_i       (bus.Funct),
    .alu_sel_o     (alu_sel),
    .funct_legal_o (funct_legal)
  );

  // State and retired-count registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

  // Next-state and raw control decode
  always_comb begin
    state_d    = state_q;
    alu_class  = ACLS_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    illegal    = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (bus.MemReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        if ((bus.OPCODES == OP_LW) || (bus.OPCODES == OP_SW)) state_d = S_MEMADR;
        else if (bus.OPCODES == OP_RTYPE) state_d = S_EXECUTE;
        else if (bus.OPCODES == OP_BEQ)   state_d = S_BRANCH;
        else if (bus.OPCODES == OP_J)     state_d = S_JUMP;
        else if (op_imm)                  state_d = S_IMMEX;
        else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.OPCODES == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (bus.MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (bus.MemReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_class = ACLS_RTYPE;
        if (funct_legal) state_d = S_ALUWB;
        else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_class = ACLS_SUB;
        branch    = 1'b1;
        pc_src    = 2'b01;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_class = ACLS_IMM;
        state_d   = S_IMMWB;
      end
      S_IMMWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables and pulses are gated by reset directly so they drop
  // the moment RST falls, without waiting for a clock edge.
  assign bus.MemRead    = mem_read;
  assign bus.MemWrite   = mem_write & RST;
  assign bus.IorD       = iord;
  assign bus.IRWrite    = ir_write & RST;
  assign bus.PCWrite    = pc_write & RST;
  assign bus.Branch     = branch & RST;
  assign bus.RegWrite   = reg_write & RST;
  assign bus.RegDst     = reg_dst;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.PCSrc      = pc_src;
  assign bus.ALUSelect  = alu_sel;
  assign bus.Illegal    = illegal & RST;
  assign bus.Retired    = retire & RST;
  assign bus.InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: vector table plus corner sequences.
module tb_multicycle_control_unit;
  import mcu_pkg::*;

  // Control word: MemRead MemWrite IorD IRWrite PCWrite Branch RegWrite
  //               RegDst MemtoReg ALUSrcA ALUSrcB[1:0] PCSrc[1:0]
  localparam logic [13:0] E_FETCH_R = 14'b1_0_0_1_1_0_0_0_0_0_01_00;
  localparam logic [13:0] E_FETCH_W = 14'b1_0_0_0_0_0_0_0_0_0_01_00;
  localparam logic [13:0] E_DECODE  = 14'b0_0_0_0_0_0_0_0_0_0_11_00;
  localparam logic [13:0] E_MEMADR  = 14'b0_0_0_0_0_0_0_0_0_1_10_00;
  localparam logic [13:0] E_MEMRD   = 14'b1_0_1_0_0_0_0_0_0_0_00_00;
  localparam logic [13:0] E_MEMWB   = 14'b0_0_0_0_0_0_1_0_1_0_00_00;
  localparam logic [13:0] E_MEMWR   = 14'b0_1_1_0_0_0_0_0_0_0_00_00;
  localparam logic [13:0] E_EXEC    = 14'b0_0_0_0_0_0_0_0_0_1_00_00;
  localparam logic [13:0] E_ALUWB   = 14'b0_0_0_0_0_0_1_1_0_0_00_00;
  localparam logic [13:0] E_BRANCH  = 14'b0_0_0_0_0_1_0_0_0_1_00_01;
  localparam logic [13:0] E_IMMEX   = 14'b0_0_0_0_0_0_0_0_0_1_10_00;
  localparam logic [13:0] E_IMMWB   = 14'b0_0_0_0_0_0_1_0_0_0_00_00;
  localparam logic [13:0] E_JUMP    = 14'b0_0_0_0_1_0_0_0_0_0_00_10;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        rdy;
    logic [13:0] ctrl;
    logic [4:0]  alu;
    logic        ill;
    logic        ret;
    logic [31:0] cnt;
  } vec_t;

  logic       CLK;
  logic       RST;
  logic [5:0] op, fn;
  logic       rdy;
  int         total, bad;
  vec_t       tbl[$];

  logic [13:0] cap_ctrl [16];
  logic [4:0]  cap_alu  [16];
  logic        cap_ill  [16];
  logic        cap_ret  [16];
  logic        cap1_ill [16];

  multicycle_control_unit_if #(.ALUSEL_W(5), .CNT_W(32)) bus0 ();
  multicycle_control_unit_if #(.ALUSEL_W(5), .CNT_W(4))  bus1 ();

  assign bus0.OPCODES  = op;
  assign bus0.Funct    = fn;
  assign bus0.MemReady = rdy;
  assign bus1.OPCODES  = op;
  assign bus1.Funct    = fn;
  assign bus1.MemReady = rdy;

  multicycle_control_unit #(.ALUSEL_W(5), .IMM_LOGIC(1), .CNT_W(32)) dut0 (
    .CLK (CLK), .RST (RST), .bus (bus0.slave)
  );
  multicycle_control_unit #(.ALUSEL_W(5), .IMM_LOGIC(0), .CNT_W(4)) dut1 (
    .CLK (CLK), .RST (RST), .bus (bus1.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] ctrl0();
    return {bus0.MemRead, bus0.MemWrite, bus0.IorD, bus0.IRWrite, bus0.PCWrite,
            bus0.Branch, bus0.RegWrite, bus0.RegDst, bus0.MemtoReg,
            bus0.ALUSrcA, bus0.ALUSrcB, bus0.PCSrc};
  endfunction

  function automatic vec_t mk(logic [5:0] o, logic [5:0] f, logic r,
                              logic [13:0] c, logic [4:0] a, logic i,
                              logic rt, logic [31:0] n);
    vec_t v;
    v.op = o; v.fn = f; v.rdy = r; v.ctrl = c; v.alu = a;
    v.ill = i; v.ret = rt; v.cnt = n;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Four-cycle instruction: FETCH, DECODE, third state, retiring fourth state
  task automatic push4(input logic [5:0] o, input logic [5:0] f,
                       input logic [13:0] c3, input logic [4:0] a3,
                       input logic [13:0] c4, input logic [31:0] n);
    tbl.push_back(mk(o, f, 1'b1, E_FETCH_R, 5'd0, 1'b0, 1'b0, n));
    tbl.push_back(mk(o, f, 1'b1, E_DECODE,  5'd0, 1'b0, 1'b0, n));
    tbl.push_back(mk(o, f, 1'b1, c3,        a3,   1'b0, 1'b0, n));
    tbl.push_back(mk(o, f, 1'b1, c4,        5'd0, 1'b0, 1'b1, n));
  endtask

  task automatic push3(input logic [5:0] o, input logic [13:0] c3,
                       input logic [4:0] a3, input logic [31:0] n);
    tbl.push_back(mk(o, 6'd0, 1'b1, E_FETCH_R, 5'd0, 1'b0, 1'b0, n));
    tbl.push_back(mk(o, 6'd0, 1'b1, E_DECODE,  5'd0, 1'b0, 1'b0, n));
    tbl.push_back(mk(o, 6'd0, 1'b1, c3,        a3,   1'b0, 1'b1, n));
  endtask

  task automatic do_reset();
    RST = 1'b0;
    rdy = 1'b1;
    #1;
    chk("rst_ctrl", ctrl0(), E_FETCH_W);
    chk("rst_pulses", {bus0.Illegal, bus0.Retired}, 2'b00);
    chk("rst_cnt0", bus0.InstrCount, 0);
    chk("rst_cnt1", bus1.InstrCount, 0);
    tick();
    RST = 1'b1;
    #1;
    chk("rel_ctrl", ctrl0(), E_FETCH_R);
  endtask

  // Run one instruction from FETCH; bit k of mask is MemReady in cycle k
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic [15:0] mask, input int exp_cyc,
                           input string nm);
    int cyc;
    cyc = 0;
    op  = o;
    fn  = f;
    for (int k = 0; k < 16; k++) begin
      cap_ctrl[k] = '0; cap_alu[k] = '0; cap_ill[k] = 1'b0;
      cap_ret[k] = 1'b0; cap1_ill[k] = 1'b0;
    end
    for (int k = 0; k < 16; k++) begin
      rdy = mask[k];
      #1;
      cap_ctrl[k] = ctrl0();
      cap_alu[k]  = bus0.ALUSelect;
      cap_ill[k]  = bus0.Illegal;
      cap_ret[k]  = bus0.Retired;
      cap1_ill[k] = bus1.Illegal;
      if (bus0.Retired || bus0.Illegal) begin
        cyc = k + 1;
        tick();
        break;
      end
      tick();
    end
    chk({nm, "_cycles"}, cyc, exp_cyc);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST   = 1'b0;
    op    = 6'd0;
    fn    = 6'd0;
    rdy   = 1'b0;

    push4(OP_RTYPE, FN_ADD, E_EXEC,   5'd0, E_ALUWB, 0);
    push4(OP_RTYPE, FN_SUB, E_EXEC,   5'd1, E_ALUWB, 1);
    push4(OP_RTYPE, FN_AND, E_EXEC,   5'd2, E_ALUWB, 2);
    push4(OP_RTYPE, FN_OR,  E_EXEC,   5'd3, E_ALUWB, 3);
    push4(OP_RTYPE, FN_SLT, E_EXEC,   5'd4, E_ALUWB, 4);
    push4(OP_SW,    6'd0,   E_MEMADR, 5'd0, E_MEMWR, 5);
    push4(OP_ADDI,  6'd0,   E_IMMEX,  5'd0, E_IMMWB, 6);
    push4(OP_ANDI,  6'd0,   E_IMMEX,  5'd2, E_IMMWB, 7);
    push4(OP_ORI,   6'd0,   E_IMMEX,  5'd3, E_IMMWB, 8);
    push3(OP_BEQ, E_BRANCH, 5'd1, 9);
    push3(OP_J,   E_JUMP,   5'd0, 10);
    // sw with a fetch wait, MemReady noise in DECODE/MEMADR, one store wait
    tbl.push_back(mk(OP_SW, 6'd0, 1'b0, E_FETCH_W, 5'd0, 1'b0, 1'b0, 11));
    tbl.push_back(mk(OP_SW, 6'd0, 1'b1, E_FETCH_R, 5'd0, 1'b0, 1'b0, 11));
    tbl.push_back(mk(OP_SW, 6'd0, 1'b0, E_DECODE,  5'd0, 1'b0, 1'b0, 11));
    tbl.push_back(mk(OP_SW, 6'd0, 1'b0, E_MEMADR,  5'd0, 1'b0, 1'b0, 11));
    tbl.push_back(mk(OP_SW, 6'd0, 1'b0, E_MEMWR,   5'd0, 1'b0, 1'b0, 11));
    tbl.push_back(mk(OP_SW, 6'd0, 1'b1, E_MEMWR,   5'd0, 1'b0, 1'b1, 11));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      op  = tbl[i].op;
      fn  = tbl[i].fn;
      rdy = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d", i),
          {ctrl0(), bus0.ALUSelect, bus0.Illegal, bus0.Retired, bus0.InstrCount},
          {tbl[i].ctrl, tbl[i].alu, tbl[i].ill, tbl[i].ret, tbl[i].cnt});
      tick();
    end

    // Reset asserted in the middle of a stalled store
    op = OP_SW; fn = 6'd0; rdy = 1'b1;
    #1;
    chk("pre_rst_cnt", bus0.InstrCount, 12);
    tick();
    tick();
    tick();
    rdy = 1'b0;
    #1;
    chk("memwr_hold", bus0.MemWrite, 1'b1);
    #1;
    RST = 1'b0;
    #1;
    chk("memwr_drop", bus0.MemWrite, 1'b0);
    chk("memwr_rst_cnt", bus0.InstrCount, 0);
    tick();
    rdy = 1'b1;
    #1;
    chk("memwr_rst_ctrl", ctrl0(), E_FETCH_W);
    RST = 1'b1;
    #1;
    chk("memwr_rel_ctrl", ctrl0(), E_FETCH_R);
    tick();
    chk("memwr_next", ctrl0(), E_DECODE);

    // lw with two MemReady-low cycles in MEMRD
    do_reset();
    run_instr(OP_LW, 6'd0, 16'hFFE7, 7, "lw_wait");
    chk("lw_wait1", cap_ctrl[3], E_MEMRD);
    chk("lw_wait2", cap_ctrl[4], E_MEMRD);
    chk("lw_memwb", {cap_ctrl[6], cap_ret[6]}, {E_MEMWB, 1'b1});
    chk("lw_cnt", bus0.InstrCount, 1);

    // beq then j
    run_instr(OP_BEQ, 6'd0, 16'hFFFF, 3, "beq");
    chk("beq_ctrl", {cap_ctrl[2], cap_alu[2]}, {E_BRANCH, 5'd1});
    run_instr(OP_J, 6'd0, 16'hFFFF, 3, "j");
    chk("j_ctrl", cap_ctrl[2], E_JUMP);
    chk("bj_cnt", bus0.InstrCount, 3);

    // Illegal opcode, then illegal funct, then a normal add
    run_instr(6'b111111, 6'd0, 16'hFFFF, 2, "ill_op");
    chk("ill_op_pulse", {cap_ill[1], cap_ret[1], cap_ctrl[1]}, {1'b1, 1'b0, E_DECODE});
    chk("ill_op_cnt", bus0.InstrCount, 3);
    run_instr(OP_RTYPE, 6'b000111, 16'hFFFF, 3, "ill_fn");
    chk("ill_fn_pulse", {cap_ill[2], cap_ret[2], cap_ctrl[2]}, {1'b1, 1'b0, E_EXEC});
    chk("ill_fn_cnt", bus0.InstrCount, 3);
    run_instr(OP_RTYPE, FN_ADD, 16'hFFFF, 4, "add");
    chk("add_exec", {cap_ctrl[2], cap_alu[2]}, {E_EXEC, 5'd0});
    chk("add_wb", {cap_ctrl[3], cap_ret[3]}, {E_ALUWB, 1'b1});
    chk("add_cnt", bus0.InstrCount, 4);

    // ori: legal with IMM_LOGIC=1, illegal in the IMM_LOGIC=0 instance
    do_reset();
    run_instr(OP_ORI, 6'd0, 16'hFFFF, 4, "ori");
    chk("ori_immex", {cap_ctrl[2], cap_alu[2]}, {E_IMMEX, 5'd3});
    chk("ori_noimm_ill", cap1_ill[1], 1'b1);
    chk("ori_noimm_cnt", bus1.InstrCount, 0);
    chk("ori_cnt", bus0.InstrCount, 1);

    // 16 retirements wrap the 4-bit counter
    do_reset();
    for (int n = 0; n < 16; n++) begin
      run_instr(OP_J, 6'd0, 16'hFFFF, 3, "j_wrap");
      if (n == 14) chk("wrap_cnt15", bus1.InstrCount, 15);
    end
    chk("wrap_cnt1", bus1.InstrCount, 0);
    chk("wrap_cnt0", bus0.InstrCount, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multicycle MIPS control unit: a registered state machine sequences each instruction over 3–5 cycles and drives the shared-ALU/shared-memory datapath. It replaces the single-cycle combinational decoder pair. It adds a memory-ready handshake, illegal-instruction detection, optional immediate-logic opcodes and a retired-instruction counter. It sits between the instruction register (opcode/funct fields) and the datapath mux/enable controls.

## Interface
- ALUSEL_W, 5, width of ALUSelect
- IMM_LOGIC, 1, 1 = andi/ori legal; 0 = they decode as illegal
- CNT_W, 32, width of InstrCount
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- OPCODES  in  6  IR[31:26]
- Funct  in  6  IR[5:0]
- MemReady  in  1  memory completes the current access this cycle
- MemRead, MemWrite, IorD, IRWrite, PCWrite, Branch, RegWrite, RegDst, MemtoReg, ALUSrcA  out  1 each  datapath controls
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- PCSrc  out  2  00 ALU result, 01 ALUOut (branch), 10 jump target
- ALUSelect  out  ALUSEL_W  ADD=0, SUB=1, AND=2, OR=3, SLT=4
- Illegal  out  1  one-cycle pulse, unsupported opcode/funct
- Retired  out  1  one-cycle pulse, instruction completed
- InstrCount  out  CNT_W  retired-instruction count

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010, andi 001100, ori 001101.
- R-type functs: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
- Unlisted outputs are 0 in every state.
- FETCH: MemRead, ALUSrcB=01, ADD. IRWrite and PCWrite assert only while MemReady=1. MemReady=1 -> DECODE, else hold.
- DECODE: ALUSrcB=11, ADD (branch target). lw/sw -> MEMADR; R -> EXECUTE; beq -> BRANCH; addi/andi/ori -> IMMEX; j -> JUMP. Other opcode, or andi/ori with IMM_LOGIC=0: Illegal pulse, -> FETCH, no retire.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. lw -> MEMRD; sw -> MEMWR.
- MEMRD: IorD, MemRead. Hold until MemReady, then -> MEMWB.
- MEMWB: RegWrite, MemtoReg; retire -> FETCH.
- MEMWR: IorD, MemWrite, held high while waiting. MemReady -> FETCH, retire.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUSelect from Funct. Legal funct -> ALUWB. Illegal funct: Illegal pulse, -> FETCH, no write, no retire.
- ALUWB: RegWrite, RegDst; retire -> FETCH.
- BRANCH: ALUSrcA=1, SUB, Branch, PCSrc=01; retire -> FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10; ALUSelect ADD/AND/OR for addi/andi/ori. -> IMMWB.
- IMMWB: RegWrite; retire -> FETCH.
- JUMP: PCSrc=10, PCWrite; retire -> FETCH.
- Retire: Retired=1 in the final state's exit cycle; InstrCount increments the same edge, wraps modulo 2^CNT_W.

## Timing
- State is registered. Outputs decode combinationally from state, OPCODES, Funct and MemReady.
- OPCODES/Funct must be stable from DECODE until the instruction returns to FETCH.
- Zero-wait cycle counts: lw 5, sw 4, R 4, addi/andi/ori 4, beq 3, j 3. Each MemReady-low cycle in FETCH/MEMRD/MEMWR adds one cycle.
- Reset (RST=0, any time, including mid-instruction): state=FETCH, InstrCount=0. While RST=0, every write enable, Illegal and Retired is forced to 0 immediately, regardless of state; MemWrite drops immediately even mid-MEMWR.
- First fetch begins on the first rising edge after RST deasserts.
- MemReady while in non-memory states is ignored.

## Structure
- Package mcu_pkg: opcode and funct constants, ALU code constants (ALUSEL_W-wide), state enum.
- Sub-module mcu_alu_decoder, combinational: (state class, OPCODES, Funct) -> ALUSelect + funct_legal.
- FSM, output decode and counter stay in the top.

## Test plan
- Reset mid-MEMWR with MemReady=0 -> MemWrite low within the same cycle; next state after release is FETCH; InstrCount=0.
- add (Funct 100000), MemReady=1 -> FETCH, DECODE, EXECUTE (ALUSelect=0), ALUWB (RegWrite=1, RegDst=1); Retired once; InstrCount=1.
- lw with MemReady low 2 cycles in MEMRD -> 7 total cycles; IorD=1 and MemRead=1 throughout the wait; MEMWB asserts MemtoReg=1 and RegWrite=1.
- beq then j -> 3 cycles each; Branch=1 with PCSrc=01 and SUB, then PCSrc=10 with PCWrite=1; InstrCount +2.
- Opcode 111111 -> Illegal pulse in DECODE, back to FETCH; no RegWrite/MemWrite; InstrCount unchanged. Funct 000111 -> Illegal in EXECUTE.
- IMM_LOGIC=0, ori -> Illegal. IMM_LOGIC=1, ori -> ALUSelect=3 in IMMEX. CNT_W=4: 16 retirements wrap InstrCount to 0.
